// File: rtl/logic_basic_debouncer_pkg.sv
// Elaboration-time helpers for the debouncer.
package logic_basic_debouncer_pkg;

    // Stability counter width: enough to hold CYCLES-1, never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    // The filter window has to be longer than the synchronizer depth, or a
    // channel reset to 1 would see the cleared synchronizer as a real fall.
    function automatic bit params_legal(input int stages, input int cycles);
        return (stages >= 1) && (cycles >= 1) && (cycles > stages);
    endfunction

endpackage

// File: rtl/logic_pkg.sv
// Shared definitions for the basic logic library.
package logic_pkg;

    // Implementation target; lets primitives pick vendor-specific attributes.
    typedef enum logic [1:0] {
        TARGET_GENERIC,
        TARGET_XILINX,
        TARGET_INTEL
    } target_t;

endpackage

// File: rtl/logic_basic_debouncer_if.sv
// Bundle of the debouncer's per-channel data signals.
interface logic_basic_debouncer_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    // Whoever drives the raw inputs and consumes the filtered results.
    modport master (output i, input o, rise, fall, changed);
    // The debouncer itself.
    modport slave  (input i, output o, rise, fall, changed);
endinterface

// File: rtl/logic_basic_debouncer_channel.sv
// One debounced bit: stability counter, accepted level and edge-event pulses.
module logic_basic_debouncer_channel
    import logic_basic_debouncer_pkg::*;
#(
    parameter int   CYCLES = 16,
    parameter logic INIT   = 1'b0
) (
    input  logic aclk,
    input  logic areset_n,
    input  logic s,
    output logic o,
    output logic rise,
    output logic fall
);
    localparam int               CNT_W    = cnt_width(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Count consecutive disagreeing samples; any agreement restarts from zero,
    // and the final disagreeing sample flips the level and fires one event.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards any partial count without an event.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            cnt_q   <= '0;
            level_q <= INIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o    = level_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/logic_basic_synchronizer.sv
// Multi-bit flop-chain synchronizer, cleared to 0 by a synchronous active-low reset.
module logic_basic_synchronizer #(
    parameter logic_pkg::target_t TARGET = logic_pkg::TARGET_GENERIC,
    parameter int                 WIDTH  = 1,
    parameter int                 STAGES = 2
) (
    input  logic             aclk,
    input  logic             areset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (TARGET == logic_pkg::TARGET_XILINX) begin : g_xilinx
            (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage_q [STAGES];

            // Shift the raw input through the chain; stage 0 is the metastable one.
            always_ff @(posedge aclk) begin
                if (!areset_n) begin
                    for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
                end else begin
                    stage_q[0] <= d;
                    for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
                end
            end

            assign q = stage_q[STAGES-1];
        end else begin : g_generic
            logic [WIDTH-1:0] stage_q [STAGES];

            // Shift the raw input through the chain; stage 0 is the metastable one.
            always_ff @(posedge aclk) begin
                if (!areset_n) begin
                    for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
                end else begin
                    stage_q[0] <= d;
                    for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
                end
            end

            assign q = stage_q[STAGES-1];
        end
    endgenerate
endmodule

// File: rtl/logic_basic_debouncer.sv
// Multi-channel input conditioner: shared synchronizer followed by per-channel filters.
module logic_basic_debouncer
    import logic_pkg::*;
    import logic_basic_debouncer_pkg::*;
#(
    parameter target_t          TARGET = TARGET_GENERIC,
    parameter int               WIDTH  = 1,
    parameter int               STAGES = 2,
    parameter int               CYCLES = 16,
    parameter logic [WIDTH-1:0] INIT   = '0
) (
    input  logic             aclk,
    input  logic             areset_n,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    generate
        if (!params_legal(STAGES, CYCLES)) begin : g_bad_params
            $error("logic_basic_debouncer: need CYCLES >= 1 and CYCLES > STAGES (CYCLES=%0d STAGES=%0d)",
                   CYCLES, STAGES);
        end
    endgenerate

    logic [WIDTH-1:0] s;

    logic_basic_synchronizer #(
        .TARGET (TARGET),
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_sync (
        .aclk     (aclk),
        .areset_n (areset_n),
        .d        (i),
        .q        (s)
    );

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic_basic_debouncer_channel #(
                .CYCLES (CYCLES),
                .INIT   (INIT[gi])
            ) u_chan (
                .aclk     (aclk),
                .areset_n (areset_n),
                .s        (s[gi]),
                .o        (o[gi]),
                .rise     (rise[gi]),
                .fall     (fall[gi])
            );
        end
    endgenerate

    // Both operands are registers, so this stays aligned with the pulses.
    assign changed = |(rise | fall);
endmodule

// File: tb/tb_logic_basic_debouncer.sv
// Scoreboard bench: a window-based reference model predicts each cycle's outputs.
module tb_logic_basic_debouncer;
    localparam int         WIDTH  = 4;
    localparam int         STAGES = 2;
    localparam int         CYCLES = 4;
    localparam logic [3:0] INIT   = 4'b1010;

    typedef struct packed {
        logic [3:0] o;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       changed;
    } exp_t;

    logic clk;
    logic areset_n;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cycle_no     = 0;

    logic_basic_debouncer_if #(.WIDTH(WIDTH)) bus ();

    logic_basic_debouncer #(
        .TARGET (logic_pkg::TARGET_GENERIC),
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .CYCLES (CYCLES),
        .INIT   (INIT)
    ) dut (
        .aclk     (clk),
        .areset_n (areset_n),
        .i        (bus.i),
        .o        (bus.o),
        .rise     (bus.rise),
        .fall     (bus.fall),
        .changed  (bus.changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: input reaches the filter STAGES edges late; a channel
    // flips once its last CYCLES filter samples (since reset) all disagree with it.
    logic [3:0] pipe[$];
    logic [3:0] shist[$];
    logic [3:0] m_o;
    bit         armed = 0;
    exp_t       expq[$];

    always @(posedge clk) begin
        logic [3:0] s_now;
        logic [3:0] r;
        logic [3:0] f;
        bit         all_diff;
        exp_t       e;
        r = '0;
        f = '0;
        cycle_no++;
        if (!areset_n) begin
            armed = 1;
            m_o   = INIT;
            pipe.delete();
            for (int n = 0; n < STAGES; n++) pipe.push_back(4'b0000);
            shist.delete();
        end else if (armed) begin
            s_now = pipe[$];
            void'(pipe.pop_back());
            pipe.push_front(bus.i);
            shist.push_back(s_now);
            if (shist.size() > CYCLES) void'(shist.pop_front());
            for (int k = 0; k < WIDTH; k++) begin
                if (shist.size() == CYCLES) begin
                    all_diff = 1;
                    foreach (shist[j]) if (shist[j][k] == m_o[k]) all_diff = 0;
                    if (all_diff) begin
                        if (m_o[k]) f[k] = 1'b1;
                        else        r[k] = 1'b1;
                    end
                end
            end
            m_o = m_o ^ (r | f);
        end
        if (armed) begin
            e.o       = m_o;
            e.rise    = r;
            e.fall    = f;
            e.changed = |(r | f);
            expq.push_back(e);
        end
    end

    // Monitor: the DUT presents a result every cycle once reset has been seen.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                tests_run++;
                if (expq.size() == 0) begin
                    tests_failed++;
                    $display("FAIL cycle %0d scoreboard: no expected entry, got o=%b", cycle_no, bus.o);
                end else begin
                    e = expq.pop_front();
                    if (bus.o !== e.o || bus.rise !== e.rise || bus.fall !== e.fall ||
                        bus.changed !== e.changed) begin
                        tests_failed++;
                        $display("FAIL cycle %0d outputs: got o=%b rise=%b fall=%b changed=%b, expected o=%b rise=%b fall=%b changed=%b",
                                 cycle_no, bus.o, bus.rise, bus.fall, bus.changed,
                                 e.o, e.rise, e.fall, e.changed);
                    end else begin
                        $display("cycle %0d ok: i=%b rst_n=%b o=%b rise=%b fall=%b changed=%b",
                                 cycle_no, bus.i, areset_n, bus.o, bus.rise, bus.fall, bus.changed);
                    end
                end
            end
        end
    end

    // Hard stop in case stimulus never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [3:0] v, input logic rn, input int n);
        bus.i    = v;
        areset_n = rn;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [3:0] v;
        logic       rn;
        int         n;
        // Reset with INIT-high channels already high; no fall may follow.
        drive(4'b1010, 1'b0, 3);
        drive(4'b1010, 1'b1, 20);
        // Clean rise then fall on channel 0.
        drive(4'b1011, 1'b1, 12);
        drive(4'b1010, 1'b1, 12);
        // Glitch of 3 cycles is rejected; 4 cycles is accepted.
        drive(4'b1011, 1'b1, 3);
        drive(4'b1010, 1'b1, 10);
        drive(4'b1011, 1'b1, 4);
        drive(4'b1010, 1'b1, 12);
        // Bounce 1,1,1,0 then steady 1.
        drive(4'b1011, 1'b1, 3);
        drive(4'b1010, 1'b1, 1);
        drive(4'b1011, 1'b1, 10);
        drive(4'b1010, 1'b1, 12);
        // Channel 0 rises and channel 3 falls together.
        drive(4'b0011, 1'b1, 12);
        // Difference on channel 1 for a few cycles, then reset mid-count.
        drive(4'b0001, 1'b1, 4);
        drive(4'b0001, 1'b0, 2);
        drive(4'b1010, 1'b1, 12);
        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            v = bus.i;
            for (int k = 0; k < WIDTH; k++)
                if ($urandom_range(5) == 0) v[k] = ~v[k];
            rn = ($urandom_range(299) != 0);
            n  = ($urandom_range(3) == 0) ? int'($urandom_range(8, 1)) : 1;
            drive(v, rn, n);
        end
        drive(bus.i, 1'b1, 2);
        @(posedge clk);
        #2;
        if (tests_run == 0) begin
            tests_failed++;
            $display("FAIL scoreboard: got 0 comparisons, required at least 1");
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/logic_basic_debouncer.md
# logic_basic_debouncer

Multi-channel input conditioner. Each channel takes an asynchronous or noisy input, synchronizes it into the `aclk` domain through `logic_basic_synchronizer`, and runs a per-channel stability counter. A channel's filtered level updates only after the synchronized input has held a new value for a programmable number of consecutive cycles. The block sits between board-level inputs (buttons, straps, slow status lines) and control logic, and reports single-cycle rise/fall events.

## Interface
- `TARGET`, `logic_pkg::TARGET_GENERIC`: target passed unchanged to the synchronizer.
- `WIDTH`, 1: number of independent channels.
- `STAGES`, 2: synchronizer depth.
- `CYCLES`, 16: consecutive stable cycles required to accept a new level. Legal range is CYCLES ≥ 1 and CYCLES > STAGES. Check this at elaboration.
- `INIT`, '0: per-channel reset value of `o` (WIDTH bits).
- `aclk`  input  1  clock; single clock domain.
- `areset_n`  input  1  reset; synchronous, active-low.
- `i`  input  WIDTH  raw inputs; may be asynchronous to `aclk`.
- `o`  output  WIDTH  debounced level.
- `rise`  output  WIDTH  one-cycle pulse when `o[k]` goes 0→1.
- `fall`  output  WIDTH  one-cycle pulse when `o[k]` goes 1→0.
- `changed`  output  1  OR-reduction of `rise | fall`; registered alongside them.

## Operation
- **Synchronization:** one `logic_basic_synchronizer` instance of width WIDTH produces `s[WIDTH-1:0]`. It receives `aclk` and `areset_n` directly.
- **Counter state:** each channel k has counter `cnt[k]`, width max(1, $clog2(CYCLES)).
- **Per-channel rules, applied at each rising edge with `areset_n`=1:**
  - `s[k] == o[k]`: `cnt[k]` ← 0.
  - `s[k] != o[k]` and `cnt[k] == CYCLES-1`: `o[k]` ← `s[k]`, `cnt[k]` ← 0, and the matching `rise[k]` or `fall[k]` ← 1.
  - `s[k] != o[k]` otherwise: `cnt[k]` ← `cnt[k]`+1.
- **Pulse clearing:** `rise` and `fall` are 0 in any cycle without an accept.
- **Bounce handling:** any return of `s[k]` to `o[k]` restarts the count from zero. A partial count is never retained.
- **CYCLES=1:** a difference is accepted on the first edge it is seen. The counter is constant 0.
- **Reset (`areset_n`=0 at an edge):** `o` ← INIT, `cnt` ← 0, `rise`/`fall`/`changed` ← 0, synchronizer cleared to 0. Asserting reset mid-count discards the count and raises no event.
- **Post-reset with INIT[k]=1:** while the synchronizer still outputs 0, `cnt[k]` counts at most STAGES cycles. It then clears once `s[k]` reads 1. Because CYCLES > STAGES, a steady-high input produces no spurious fall.
- **Independence:** channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.

## Timing
- **Latency:** a clean step on `i[k]`, sampled at edge E, updates `o[k]` at edge E+STAGES+CYCLES-1. The event pulse is high for exactly the cycle following that edge.
- **Glitch rejection:** a pulse on `s[k]` lasting ≤ CYCLES-1 cycles never reaches `o[k]`.
- **Event spacing:** the minimum spacing between two events on one channel is CYCLES cycles.
- **Registered outputs:** all outputs are registered; no combinational path from `i`.
- **Throughput:** no back-pressure, no handshake. Events are pulses and are never queued.

## Structure
- **Package:** no new package types. Reuse `logic_pkg::target_t`.
- **Counter width:** a localparam inside the module.
- **Sub-module:** the natural one is `logic_basic_debouncer_channel` (one bit: counter, compare, level register, pulse registers). Instantiate it WIDTH times in a generate loop after the shared synchronizer.
- **Output reduction:** compute `changed` in the top level from registered channel events.

## Test plan
- **Reset values:** INIT=2'b10, WIDTH=2, hold `areset_n`=0 for 3 cycles → `o`=2'b10, `rise`=`fall`=0, `changed`=0.
- **Clean rise:** STAGES=2, CYCLES=4, `i[0]` 0→1 sampled at edge 10 → `o[0]`=1 after edge 15. `rise[0]`=1 only in the cycle after edge 15. `fall`=0 throughout.
- **Glitch rejection:** CYCLES=4, `i[0]` high for exactly 3 cycles then low → `o[0]` stays 0, no pulses. A 4-cycle high is accepted.
- **Bounce:** `i[0]` pattern 1,1,1,0,1,1,1,1 after synchronization (CYCLES=4) → acceptance occurs 4 cycles after the final 0→1, not earlier.
- **Multi-channel simultaneous:** WIDTH=4, `i[0]` rises and `i[3]` falls on the same edge → `rise`=4'b0001 and `fall`=4'b1000 in the same cycle, `changed`=1 for one cycle.
- **Reset mid-count and INIT=1:**
  - Drive a difference for 2 cycles, then assert reset → no event; `o`=INIT afterward.
  - With INIT=1 and `i` held 1 across reset → `fall` never asserts.
